// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential multiplier.
// The caller drives sign, start and both operands; the multiplier returns product, ready and busy.
// The signal set matches the restoring divider, so either unit can sit behind the same caller.
interface seq_multiplier_if #(
    parameter int WIDTH = 36
);
    logic                   sign;
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic [2*WIDTH-1:0]     product;
    logic                   ready;
    logic                   busy;

    modport master (
        output sign, start, multiplicand, multiplier,
        input  product, ready, busy
    );

    modport slave (
        input  sign, start, multiplicand, multiplier,
        output product, ready, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or twos complement.
// Latency: ready rises WIDTH+1 clocks after the edge that sees the start rising edge.
// Backpressure: none; a new start edge aborts any run, and the result is held until the next launch.
module seq_multiplier #(
    parameter int WIDTH = 36
) (
    input  logic           clk,
    input  logic           reset,
    seq_multiplier_if.slave io_mul
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_last_start;
    logic                 r_neg;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand_sh;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_start_edge;
    logic                 w_done;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    // A held-high start launches once; only a 0->1 transition counts.
    assign w_start_edge = io_mul.start & ~r_last_start;
    // The last iteration has brought the count to zero, so this edge loads the result.
    assign w_done       = (r_state == RUN) && (r_count == '0);

    // Operand magnitudes. The most negative value negates onto itself, and its bit pattern
    // is the correct unsigned magnitude 2^(WIDTH-1).
    assign w_a_mag = (io_mul.sign & io_mul.multiplicand[WIDTH-1]) ? -io_mul.multiplicand
                                                                  : io_mul.multiplicand;
    assign w_b_mag = (io_mul.sign & io_mul.multiplier[WIDTH-1])   ? -io_mul.multiplier
                                                                  : io_mul.multiplier;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a start edge wins in every state, including a restart during RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next_state = RUN;
            RUN:     if (w_start_edge) w_next_state = RUN;
                     else if (w_done)  w_next_state = DONE;
            DONE:    if (w_start_edge) w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: the launch loads the operands, RUN runs a fixed WIDTH iterations, and completion applies the sign.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_start <= 1'b0;
            r_neg        <= 1'b0;
            r_count      <= '0;
            r_acc        <= '0;
            r_mcand_sh   <= '0;
            r_mplier     <= '0;
            r_product    <= '0;
        end else begin
            r_last_start <= io_mul.start;
            if (w_start_edge) begin
                r_neg      <= io_mul.sign & (io_mul.multiplicand[WIDTH-1] ^ io_mul.multiplier[WIDTH-1]);
                r_acc      <= '0;
                r_mcand_sh <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier   <= w_b_mag;
                r_count    <= CW'(WIDTH);
            end else if (r_state == RUN) begin
                if (r_count != '0) begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand_sh;
                    end
                    r_mcand_sh <= r_mcand_sh << 1;
                    r_mplier   <= r_mplier >> 1;
                    r_count    <= r_count - CW'(1);
                end else begin
                    r_product <= r_neg ? -r_acc : r_acc;
                end
            end
        end
    end

    // Both flags are decoded from the state, so they can never be high together.
    assign io_mul.ready   = (r_state == DONE);
    assign io_mul.busy    = (r_state == RUN);
    assign io_mul.product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier. It runs one 8-bit instance and one 36-bit instance.
// Expected products come from signed or unsigned integer multiplication of the operands.
// Each scenario task checks its own results inline.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(8))  if8();
    seq_multiplier_if #(.WIDTH(36)) if36();

    seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .io_mul(if8.slave));
    seq_multiplier #(.WIDTH(36)) dut36 (.clk(clk), .reset(reset), .io_mul(if36.slave));

    int total = 0;
    int bad   = 0;

    // Reference product: interpret the operands as integers and multiply, then keep 2*w bits.
    function automatic logic [71:0] ref_product(input logic s, input int w,
                                                input logic [35:0] a, input logic [35:0] b);
        logic signed [73:0] sa, sb, p, mask;
        sa = $signed({38'b0, a});
        sb = $signed({38'b0, b});
        if (s && a[w-1]) sa = sa - (74'sd1 <<< w);
        if (s && b[w-1]) sb = sb - (74'sd1 <<< w);
        p    = sa * sb;
        mask = (74'sd1 <<< (2 * w)) - 74'sd1;
        return 72'(p & mask);
    endfunction

    task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        if8.sign = s; if8.multiplicand = a; if8.multiplier = b; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
    endtask

    task automatic launch36(input logic s, input logic [35:0] a, input logic [35:0] b);
        @(posedge clk); #1;
        if36.sign = s; if36.multiplicand = a; if36.multiplier = b; if36.start = 1'b1;
        @(posedge clk); #1;
        if36.start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (if8.product !== 16'h0)  begin bad++; $display("FAIL rst_prod8 got=%h exp=0", if8.product); end
        total++; if (if8.ready !== 1'b0)     begin bad++; $display("FAIL rst_ready8 got=%b exp=0", if8.ready); end
        total++; if (if8.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy8 got=%b exp=0", if8.busy); end
        total++; if (if36.product !== 72'h0) begin bad++; $display("FAIL rst_prod36 got=%h exp=0", if36.product); end
        total++; if (if36.ready !== 1'b0)    begin bad++; $display("FAIL rst_ready36 got=%b exp=0", if36.ready); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (if8.ready !== 1'b0 || if8.busy !== 1'b0)
            begin bad++; $display("FAIL idle_flags8 got=%b%b exp=00", if8.ready, if8.busy); end
    endtask

    task automatic test_latency;
        launch8(1'b0, 8'hFF, 8'hFF);
        for (int i = 0; i <= 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            total++;
            if (if8.ready !== (i == 9) || if8.busy !== (i < 9)) begin
                bad++; $display("FAIL lat_flags clk=%0d got r=%b b=%b exp r=%b b=%b",
                                i, if8.ready, if8.busy, i == 9, i < 9);
            end
        end
        total++; if (if8.product !== 16'hFE01) begin bad++; $display("FAIL lat_prod got=%h exp=fe01", if8.product); end
    endtask

    task automatic test_signed;
        logic [8:0]  s_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0]  a_t [4] = '{8'hFD, 8'hFD, 8'h80, 8'h80};
        logic [7:0]  b_t [4] = '{8'h07, 8'h07, 8'h80, 8'h01};
        logic [15:0] e_t [4] = '{16'hFFEB, 16'h06EB, 16'h4000, 16'hFF80};
        for (int k = 0; k < 4; k++) begin
            launch8(s_t[k][0], a_t[k], b_t[k]);
            repeat (9) @(posedge clk);
            #1;
            total++;
            if (if8.ready !== 1'b1 || if8.product !== e_t[k]) begin
                bad++; $display("FAIL signed_%0d got r=%b p=%h exp r=1 p=%h", k, if8.ready, if8.product, e_t[k]);
            end
        end
    endtask

    task automatic test_start_held;
        @(posedge clk); #1;
        if8.sign = 1'b0; if8.multiplicand = 8'h00; if8.multiplier = 8'hC8; if8.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            total++;
            if (if8.ready !== (i >= 10) || if8.busy !== (i < 10)) begin
                bad++; $display("FAIL held_flags clk=%0d got r=%b b=%b exp r=%b b=%b",
                                i, if8.ready, if8.busy, i >= 10, i < 10);
            end
        end
        total++; if (if8.product !== 16'h0) begin bad++; $display("FAIL held_prod got=%h exp=0", if8.product); end
        if8.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (if8.ready !== 1'b1 || if8.product !== 16'h0)
            begin bad++; $display("FAIL held_after got r=%b p=%h exp r=1 p=0", if8.ready, if8.product); end
    endtask

    task automatic test_restart;
        launch8(1'b0, 8'h12, 8'h34);
        repeat (2) @(posedge clk);
        #1;
        if8.multiplicand = 8'h0A; if8.multiplier = 8'h0A; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            total++;
            if (if8.ready !== (i == 9) || if8.product === 16'h03A8) begin
                bad++; $display("FAIL restart clk=%0d got r=%b p=%h exp r=%b p!=03a8", i, if8.ready, if8.product, i == 9);
            end
        end
        total++; if (if8.product !== 16'h0064) begin bad++; $display("FAIL restart_prod got=%h exp=0064", if8.product); end
    endtask

    task automatic test_reset_midrun;
        int seen;
        launch36(1'b1, 36'h9_1234_5678, 36'h0_0ABC_DEF1);
        launch8(1'b0, 8'h77, 8'h55);
        #3;
        reset = 1'b1;
        #1;
        total++; if (if36.product !== 72'h0 || if36.ready !== 1'b0 || if36.busy !== 1'b0)
            begin bad++; $display("FAIL midrst36 got p=%h r=%b b=%b exp 0 0 0", if36.product, if36.ready, if36.busy); end
        total++; if (if8.product !== 16'h0 || if8.ready !== 1'b0 || if8.busy !== 1'b0)
            begin bad++; $display("FAIL midrst8 got p=%h r=%b b=%b exp 0 0 0", if8.product, if8.ready, if8.busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (if36.ready === 1'b1 || if8.ready === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL post_rst_ready got=%0d cycles exp=0", seen); end
    endtask

    task automatic test_random36;
        logic        s;
        logic [35:0] a, b;
        logic [71:0] exp_p;
        int          n;
        for (int k = 0; k < 25; k++) begin
            s = 1'($urandom);
            a = {4'($urandom), 32'($urandom)};
            b = {4'($urandom), 32'($urandom)};
            if (k == 0) begin s = 1'b1; a = 36'h8_0000_0000; b = 36'h8_0000_0000; end
            if (k == 1) begin s = 1'b0; a = 36'hF_FFFF_FFFF; b = 36'hF_FFFF_FFFF; end
            if (k == 2) begin s = 1'b1; a = 36'hF_FFFF_FFFF; b = 36'h7_FFFF_FFFF; end
            exp_p = ref_product(s, 36, a, b);
            launch36(s, a, b);
            total++; if (if36.ready !== 1'b0 || if36.busy !== 1'b1)
                begin bad++; $display("FAIL rnd36_launch_%0d got r=%b b=%b exp r=0 b=1", k, if36.ready, if36.busy); end
            n = 0;
            while (if36.ready !== 1'b1 && n < 45) begin @(posedge clk); #1; n++; end
            total++;
            if (n !== 37 || if36.product !== exp_p) begin
                bad++; $display("FAIL rnd36_%0d s=%b a=%h b=%h got p=%h lat=%0d exp p=%h lat=37",
                                k, s, a, b, if36.product, n, exp_p);
            end
        end
    endtask

    task automatic test_random8;
        logic        s;
        logic [7:0]  a, b;
        logic [71:0] exp_p;
        int          n;
        for (int k = 0; k < 20; k++) begin
            s = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            exp_p = ref_product(s, 8, {28'b0, a}, {28'b0, b});
            launch8(s, a, b);
            n = 0;
            while (if8.ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            total++;
            if (n !== 9 || if8.product !== exp_p[15:0]) begin
                bad++; $display("FAIL rnd8_%0d s=%b a=%h b=%h got p=%h lat=%0d exp p=%h lat=9",
                                k, s, a, b, if8.product, n, exp_p[15:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        if8.sign = 1'b0;  if8.start = 1'b0;  if8.multiplicand = '0;  if8.multiplier = '0;
        if36.sign = 1'b0; if36.start = 1'b0; if36.multiplicand = '0; if36.multiplier = '0;
        test_reset();
        test_latency();
        test_signed();
        test_start_held();
        test_restart();
        test_random8();
        test_random36();
        test_reset_midrun();
        test_random36();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
